// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine credit/payout controller.
// Holds the controller state enum, the paytable values and the winning digit.
// No ports; imported by slot_payout and slot_payout_rules.
package slot_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SPIN   = 2'd1,
      EVAL   = 2'd2,
      PAYOUT = 2'd3
   } state_t;

   localparam int WIN_TRIPLE7 = 50;
   localparam int WIN_TRIPLE  = 20;
   localparam int WIN_PAIR    = 2;

   localparam logic [3:0] SEVEN = 4'h7;

endpackage

// File: rtl/slot_payout_rules.sv
// Paytable: maps three captured reel digits to the nominal win value.
// Ports: digits[11:0] in ([11:8] reel 1, [7:4] reel 2, [3:0] reel 3), win[W-1:0] out.
// Purely combinational, zero latency, no flow control.
module slot_payout_rules
   import slot_pkg::*;
#(
   parameter int W = 10
) (
   input  logic [11:0]  digits,
   output logic [W-1:0] win
);

   logic [3:0] r1, r2, r3;

   assign r1 = digits[11:8];
   assign r2 = digits[7:4];
   assign r3 = digits[3:0];

   always_comb begin
      win = '0;
      if ((r1 == r2) && (r2 == r3)) begin
         win = (r1 == SEVEN) ? W'(WIN_TRIPLE7) : W'(WIN_TRIPLE);
      end else if ((r1 == r2) || (r2 == r3)) begin
         win = W'(WIN_PAIR);
      end
   end

endmodule

// File: rtl/slot_payout.sv
// Credit/payout controller: charges one credit per spin, scores the result, pays the win back.
// Ports: CLOCK_50, reset (sync, active-high), spin_start/spin_done/spin_value in;
//        spin_go, credits, win_amount, busy, no_credit out. Optional macro SLOT_PAYOUT_ROLLUP_EN.
module slot_payout
   import slot_pkg::*;
#(
   parameter int CREDIT_W      = 10,
   parameter int START_CREDITS = 100,
   parameter int MAX_CREDITS   = 999,
   parameter int TICK_DIV      = 5_000_000
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                spin_start,
   input  logic                spin_done,
   input  logic [11:0]         spin_value,
   output logic                spin_go,
   output logic [CREDIT_W-1:0] credits,
   output logic [CREDIT_W-1:0] win_amount,
   output logic                busy,
   output logic                no_credit
);

   state_t              state, state_nxt;
   logic [11:0]         digits;
   logic [CREDIT_W-1:0] win_calc;
   logic                take;

   slot_payout_rules #(.W(CREDIT_W)) u_rules (
      .digits (digits),
      .win    (win_calc)
   );

   // A spin is only accepted from IDLE with at least one credit to charge.
   assign take      = (state == IDLE) && spin_start && (credits != '0);
   assign spin_go   = (state == SPIN);
   assign busy      = (state != IDLE);
   assign no_credit = (credits == '0);

`ifdef SLOT_PAYOUT_ROLLUP_EN
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [TW-1:0]       tick;
   logic [CREDIT_W-1:0] remaining;
   logic                tick_end;
   logic                at_cap_next;
   logic                payout_last;

   assign tick_end    = (tick == TW'(TICK_DIV - 1));
   // Credits will hit the ceiling on this tick, so the rest of the win is dropped.
   assign at_cap_next = (credits >= CREDIT_W'(MAX_CREDITS - 1));
   assign payout_last = tick_end && ((remaining == CREDIT_W'(1)) || at_cap_next);
`else
   localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W + 1)'(MAX_CREDITS);

   logic [CREDIT_W:0] sum;

   // One extra bit so the saturation compare sees the true sum.
   assign sum = {1'b0, credits} + {1'b0, win_amount};
`endif

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (take) state_nxt = SPIN;
         SPIN:   if (spin_done) state_nxt = EVAL;
         EVAL:   state_nxt = (win_calc != '0) ? PAYOUT : IDLE;
`ifdef SLOT_PAYOUT_ROLLUP_EN
         PAYOUT: if (payout_last) state_nxt = IDLE;
`else
         PAYOUT: state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         credits    <= CREDIT_W'(START_CREDITS);
         win_amount <= '0;
         digits     <= '0;
`ifdef SLOT_PAYOUT_ROLLUP_EN
         tick       <= '0;
         remaining  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  credits    <= credits - CREDIT_W'(1);
                  win_amount <= '0;
               end
            end
            SPIN: begin
               if (spin_done) digits <= spin_value;
            end
            EVAL: begin
               win_amount <= win_calc;
`ifdef SLOT_PAYOUT_ROLLUP_EN
               tick      <= '0;
               remaining <= win_calc;
`endif
            end
            PAYOUT: begin
`ifdef SLOT_PAYOUT_ROLLUP_EN
               if (tick_end) begin
                  tick      <= '0;
                  credits   <= credits + CREDIT_W'(1);
                  remaining <= at_cap_next ? '0 : remaining - CREDIT_W'(1);
               end else begin
                  tick <= tick + TW'(1);
               end
`else
               credits <= (sum > MAX_EXT) ? CREDIT_W'(MAX_CREDITS) : sum[CREDIT_W-1:0];
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_slot_payout.sv
// Bench for slot_payout: three instances (start balances 100, 998, 1) share one stimulus
// stream; a transaction-level model of balances and wins checks every spin.
// Works with or without SLOT_PAYOUT_ROLLUP_EN (TICK_DIV = 4 here).
module tb_slot_payout;

   localparam int N   = 3;
   localparam int MAX = 999;

   logic       CLOCK_50;
   logic       reset;
   logic       spin_start;
   logic       spin_done;
   logic [11:0] spin_value;

   logic [N-1:0] spin_go_v, busy_v, no_credit_v;
   logic [9:0]   cred [N];
   logic [9:0]   win  [N];

   int start_bal [N] = '{100, 998, 1};
   int m_bal [N];
   int m_win [N];
   int total = 0;
   int bad   = 0;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int SC = (g == 0) ? 100 : (g == 1) ? 998 : 1;
      slot_payout #(
         .CREDIT_W      (10),
         .START_CREDITS (SC),
         .MAX_CREDITS   (MAX),
         .TICK_DIV      (4)
      ) u_dut (
         .CLOCK_50   (CLOCK_50),
         .reset      (reset),
         .spin_start (spin_start),
         .spin_done  (spin_done),
         .spin_value (spin_value),
         .spin_go    (spin_go_v[g]),
         .credits    (cred[g]),
         .win_amount (win[g]),
         .busy       (busy_v[g]),
         .no_credit  (no_credit_v[g])
      );
   end

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // Paytable from the game rules.
   function automatic int win_of(input logic [11:0] v);
      int a, b, c;
      a = int'(v[11:8]);
      b = int'(v[7:4]);
      c = int'(v[3:0]);
      if (a == b && b == c) return (a == 7) ? 50 : 20;
      if (a == b || b == c) return 2;
      return 0;
   endfunction

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [N-1:0] exp_busy, input logic [N-1:0] exp_go);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s credits[%0d]", tag, i), 32'(cred[i]), m_bal[i]);
         check($sformatf("%s win[%0d]", tag, i), 32'(win[i]), m_win[i]);
         check($sformatf("%s busy[%0d]", tag, i), 32'(busy_v[i]), 32'(exp_busy[i]));
         check($sformatf("%s spin_go[%0d]", tag, i), 32'(spin_go_v[i]), 32'(exp_go[i]));
         check($sformatf("%s no_credit[%0d]", tag, i), 32'(no_credit_v[i]), (m_bal[i] == 0) ? 1 : 0);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_bal[i] = start_bal[i];
         m_win[i] = 0;
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy_v != '0 && n < 1000) begin
         step();
         n++;
      end
      check({tag, " idle_bound"}, (n < 1000) ? 1 : 0, 1);
   endtask

   // Start a spin, optionally with spin_done in the same cycle and a second
   // spin_start while spinning; stops after the EVAL edge (returns the taken mask).
   task automatic start_and_done(input string tag, input logic [11:0] v, input bit together,
                                 input bit extra_start, input int dwell, output logic [N-1:0] took);
      spin_value = v;
      spin_start = 1'b1;
      spin_done  = together;
      for (int i = 0; i < N; i++) begin
         took[i] = (m_bal[i] >= 1);
         if (took[i]) begin
            m_bal[i]--;
            m_win[i] = 0;
         end
      end
      step();
      spin_start = 1'b0;
      spin_done  = 1'b0;
      check_all({tag, " start"}, took, took);
      repeat (dwell) step();
      if (extra_start) begin
         spin_start = 1'b1;
         step();
         spin_start = 1'b0;
         check_all({tag, " extra_start"}, took, took);
      end
      spin_done = 1'b1;
      step();
      spin_done = 1'b0;
      check_all({tag, " eval"}, took, '0);
   endtask

   task automatic do_spin(input string tag, input logic [11:0] v, input bit together,
                          input bit extra_start, input int dwell);
      logic [N-1:0] took, paying;
      int w;
      start_and_done(tag, v, together, extra_start, dwell, took);
      w = win_of(v);
      for (int i = 0; i < N; i++) begin
         paying[i] = took[i] && (w != 0);
         if (took[i]) m_win[i] = w;
      end
      step();
      check_all({tag, " win"}, paying, '0);
      for (int i = 0; i < N; i++)
         if (took[i]) m_bal[i] = (m_bal[i] + w > MAX) ? MAX : m_bal[i] + w;
`ifndef SLOT_PAYOUT_ROLLUP_EN
      step();
      check_all({tag, " paid_next_cycle"}, '0, '0);
`endif
      wait_idle(tag);
      check_all({tag, " paid"}, '0, '0);
   endtask

   initial begin
      logic [N-1:0] took;
      logic [11:0]  v;
      int           pre0;

      reset      = 1'b1;
      spin_start = 1'b0;
      spin_done  = 1'b0;
      spin_value = '0;
      model_reset();
      step();
      step();
      reset = 1'b0;
      check_all("reset", '0, '0);

      // Directed spins: no win, pair, triple, triple seven (saturates instance 1).
      do_spin("nowin_123", 12'h123, 1'b0, 1'b0, 2);
      do_spin("pair_AAB", 12'hAAB, 1'b0, 1'b0, 0);
      do_spin("triple_555", 12'h555, 1'b0, 1'b0, 1);
      do_spin("triple7_777", 12'h777, 1'b0, 1'b1, 3);

      // spin_done while idle must change nothing.
      spin_value = 12'h777;
      spin_done  = 1'b1;
      step();
      spin_done = 1'b0;
      check_all("idle_done", '0, '0);
      step();
      check_all("idle_done_after", '0, '0);

      // Start and done together in IDLE: the start wins, the done is dropped.
      do_spin("together_321", 12'h321, 1'b1, 1'b0, 2);

      // Reset while a triple-seven payout is in progress.
      start_and_done("reset_mid", 12'h777, 1'b0, 1'b0, 1, took);
      pre0 = m_bal[0];
      step();
`ifdef SLOT_PAYOUT_ROLLUP_EN
      repeat (40) step();
      check("reset_mid ticks credits[0]", 32'(cred[0]), pre0 + 10);
`else
      check("reset_mid pending credits[0]", 32'(cred[0]), pre0);
`endif
      check("reset_mid busy[0]", 32'(busy_v[0]), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_reset();
      check_all("reset_mid after", '0, '0);

      // Randomised spins, digits biased toward 5 and 7 so wins are common.
      for (int k = 0; k < 24; k++) begin
         for (int d = 0; d < 3; d++) begin
            if ($urandom_range(0, 1) == 0) v[d*4 +: 4] = 4'($urandom_range(0, 15));
            else v[d*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h7 : 4'h5;
         end
         do_spin($sformatf("rand%0d", k), v, 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 4)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
